// File: rtl/cache_pkg.sv
// cache_pkg
// Shared cache-line geometry, owner identifiers and refill FSM states for the
// cache refill path. Imported by the refill controller and its arbiter.
//
// Contents:
//   LINE_WORDS / LINE_BYTES      line geometry (16 words, 64 bytes)
//   OFFSET_W / INDEX_W / TAG_W   address field widths
//   owner_t                      which cache owns a refill
//   refill_state_t               refill controller FSM states
//   grant_to_owner()             one-hot grant vector to owner_t
package cache_pkg;

  localparam int LINE_WORDS = 16;
  localparam int LINE_BYTES = 64;
  localparam int OFFSET_W   = 6;
  localparam int INDEX_W    = 7;
  localparam int TAG_W      = 19;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } refill_state_t;

  // Grant bit 0 is the icache, bit 1 the dcache.
  function automatic owner_t grant_to_owner(input logic [1:0] grant);
    return grant[1] ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/refill_rr_arbiter.sv
// refill_rr_arbiter
// Two-way round-robin arbiter between the icache and dcache. On a tie the
// requester that was not granted last wins; a sole requester always wins.
//
// Ports:
//   enable      in   arbitration allowed this cycle (grant is zero otherwise)
//   req_i       in   icache request
//   req_d       in   dcache request
//   last_grant  in   owner granted most recently
//   grant       out  one-hot grant, bit 0 = icache, bit 1 = dcache
module refill_rr_arbiter
  import cache_pkg::*;
(
  input  logic       enable,
  input  logic       req_i,
  input  logic       req_d,
  input  owner_t     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req_i && req_d) begin
        grant = (last_grant == OWNER_I) ? 2'b10 : 2'b01;
      end else if (req_i) begin
        grant = 2'b01;
      end else if (req_d) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/cache_refill_controller.sv
// cache_refill_controller
// Sequences 64-byte line refills for the icache and dcache over one shared
// 32-bit memory read port: round-robin arbitration, 16 single-word reads,
// each returned word forwarded with its index, and a done pulse per line.
//
// Ports:
//   Clock, Reset                 rising-edge clock, synchronous active-high reset
//   IReq, IAddr, IDone           icache miss request / address / done pulse
//   DReq, DAddr, DDone           dcache miss request / address / done pulse
//   FillValid, FillOwner,
//   FillIndex, FillData          registered returned word (owner 0 = I, 1 = D)
//   MemReq, MemAddr, MemReady    memory read request channel
//   MemValid, MemData            memory read response channel
module cache_refill_controller
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IDone,
  input  logic              DReq,
  input  logic [ADDR_W-1:0] DAddr,
  output logic              DDone,
  output logic              FillValid,
  output logic              FillOwner,
  output logic [3:0]        FillIndex,
  output logic [31:0]       FillData,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemReady,
  input  logic              MemValid,
  input  logic [31:0]       MemData
);

  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam logic [3:0] LAST_WORD = 4'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_BYTES - 1);

  refill_state_t state, next_state;
  owner_t        owner, last_grant;

  logic [LINE_W-1:0] line_addr;
  logic [3:0]        count;
  logic [3:0]        count_next;
  logic [1:0]        grant;
  logic              grant_any;
  logic [ADDR_W-1:0] sel_addr;
  logic              req_i_eff, req_d_eff;
  logic              load_line, word_done, finish, last_word;

  // A requester still sees its Done in the cycle IDLE is re-entered and only
  // drops Req on that edge, so mask it to avoid re-granting a finished line.
  assign req_i_eff  = IReq & ~IDone;
  assign req_d_eff  = DReq & ~DDone;
  assign grant_any  = |grant;
  assign sel_addr   = grant[1] ? DAddr : IAddr;
  assign last_word  = (count == LAST_WORD);
  assign count_next = count + 4'd1;

  refill_rr_arbiter u_arbiter (
    .enable     (state == ST_IDLE),
    .req_i      (req_i_eff),
    .req_d      (req_d_eff),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (grant_any) next_state = ST_ISSUE;
      ST_ISSUE: if (MemReady)  next_state = ST_WAIT;
      ST_WAIT:  if (MemValid)  next_state = last_word ? ST_DONE : ST_ISSUE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    MemReq    = 1'b0;
    load_line = 1'b0;
    word_done = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE:  load_line = grant_any;
      ST_ISSUE: MemReq    = 1'b1;
      ST_WAIT:  word_done = MemValid;
      ST_DONE:  finish    = 1'b1;
      default:  ;
    endcase
  end

  // MemAddr is loaded ahead of each ISSUE so it is valid the same cycle
  // MemReq rises.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      owner      <= OWNER_I;
      last_grant <= OWNER_D;
      line_addr  <= '0;
      count      <= '0;
      MemAddr    <= '0;
      FillValid  <= 1'b0;
      FillOwner  <= 1'b0;
      FillIndex  <= '0;
      FillData   <= '0;
      IDone      <= 1'b0;
      DDone      <= 1'b0;
    end else begin
      FillValid <= 1'b0;
      IDone     <= 1'b0;
      DDone     <= 1'b0;

      if (load_line) begin
        owner     <= grant_to_owner(grant);
        line_addr <= sel_addr[ADDR_W-1:OFFSET_W];
        count     <= '0;
        MemAddr   <= sel_addr & ~OFFSET_MASK;
      end

      if (word_done) begin
        FillValid <= 1'b1;
        FillData  <= MemData;
        FillIndex <= count;
        FillOwner <= owner;
        if (!last_word) begin
          count   <= count_next;
          MemAddr <= {line_addr, count_next, 2'b00};
        end
      end

      if (finish) begin
        IDone      <= (owner == OWNER_I);
        DDone      <= (owner == OWNER_D);
        last_grant <= owner;
      end
    end
  end

endmodule
